// File: rtl/psum_accumulator.sv
// Accumulates NUM_TILES signed partial sums per output element with saturation,
// and hands each completed result to a one-entry valid/ready output register.
//
// state | meaning
// IDLE  | no beat of the current vector accepted yet (cnt == 0)
// ACCUM | part of a vector accumulated in acc (cnt > 0)
module psum_accumulator #(
  parameter int PARTIAL_SUM_BW = 20,
  parameter int ACC_BW         = 24,
  parameter int NUM_TILES      = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [PARTIAL_SUM_BW-1:0] in_sum,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [ACC_BW-1:0]         out_sum,
  output logic                             out_sat
);

  localparam int CNT_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TILES - 1);
  localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state;
  logic signed [ACC_BW-1:0] acc;
  logic [CNT_W-1:0]         cnt;
  logic                     sat;

  logic                     is_last;
  logic                     accept;
  logic signed [ACC_BW-1:0] acc_base;
  logic [ACC_BW:0]          sum_ext;
  logic                     ovf;
  logic signed [ACC_BW-1:0] clamped;
  logic                     sat_next;

  always_comb begin
    is_last  = (cnt == LAST);
    in_ready = !flush && !(out_valid && !out_ready && is_last);
    accept   = in_valid && in_ready;
    acc_base = (state == IDLE) ? '0 : acc;
    // one guard bit is enough: the sum of two ACC_BW-bit values never wraps
    sum_ext  = {acc_base[ACC_BW-1], acc_base}
             + {{(ACC_BW+1-PARTIAL_SUM_BW){in_sum[PARTIAL_SUM_BW-1]}}, in_sum};
    ovf      = sum_ext[ACC_BW] ^ sum_ext[ACC_BW-1];
    if (!ovf)
      clamped = sum_ext[ACC_BW-1:0];
    else if (sum_ext[ACC_BW])
      clamped = ACC_MIN;
    else
      clamped = ACC_MAX;
    sat_next = ((state == ACCUM) && sat) || ovf;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // a final-beat load below overrides this drain, giving back-to-back results
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
        sat   <= 1'b0;
      end else if (accept) begin
        if (is_last) begin
          out_sum   <= clamped;
          out_sat   <= sat_next;
          out_valid <= 1'b1;
          state     <= IDLE;
          acc       <= '0;
          cnt       <= '0;
          sat       <= 1'b0;
        end else begin
          state <= ACCUM;
          acc   <= clamped;
          cnt   <= cnt + CNT_W'(1);
          sat   <= sat_next;
        end
      end
    end
  end

endmodule
